// File: rtl/qjx_stamp_fifo.sv
// rtl/qjx_stamp_fifo.sv - stamped FIFO with registered head; optional stamp path under QJX_STAMP_FIFO_STAMP_EN
module qjx_stamp_fifo #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [0:1][0:3]        in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:1][0:3]        out_data,
  output logic [TS_W-1:0]        out_stamp,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [0:1][0:3] r_mem [DEPTH];
  logic [0:1][0:3] r_out_data;

  logic            w_push;
  logic            w_pop;
  logic            w_head_from_in;
  logic [AW-1:0]   w_rptr_nxt;
  logic [CW-1:0]   w_count_nxt;

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;
  assign out_data  = r_out_data;

  // Next read pointer and occupancy for a cycle without flush or reset
  always_comb begin
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (w_pop) begin
      w_rptr_nxt = r_rptr + 1'b1;
    end
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // The new head is the word being written only when it lands exactly at the next read slot
  assign w_head_from_in = w_push && (r_wptr == w_rptr_nxt);

  // Pointers and occupancy; flush wins over push/pop and drops the incoming word
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // Registered head word; holds its last value whenever the FIFO becomes empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data <= '0;
    end else if (!flush && (w_count_nxt != '0)) begin
      r_out_data <= w_head_from_in ? in_data : r_mem[w_rptr_nxt];
    end
  end

`ifdef QJX_STAMP_FIFO_STAMP_EN
  logic [TS_W-1:0] r_stamp;
  logic [TS_W-1:0] r_smem [DEPTH];
  logic [TS_W-1:0] r_out_stamp;

  assign out_stamp = r_out_stamp;

  // Free-running cycle stamp, wraps from all-ones to zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stamp <= '0;
    end else begin
      r_stamp <= r_stamp + 1'b1;
    end
  end

  // Stamp storage alongside each entry, captured in the accepting cycle
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_push) begin
      r_smem[r_wptr] <= r_stamp;
    end
  end

  // Registered head stamp, tracking the head word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_stamp <= '0;
    end else if (!flush && (w_count_nxt != '0)) begin
      r_out_stamp <= w_head_from_in ? r_stamp : r_smem[w_rptr_nxt];
    end
  end
`else
  assign out_stamp = '0;
`endif

endmodule

// File: doc/qjx_stamp_fifo.md
QJX_STAMP_FIFO -- requirements
Module: qjx_stamp_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TS_W, default 64, meaning the width of the cycle stamp, sized to a `time` value.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  upstream word present.
REQ-006 The block SHALL have port in_data  input  [0:1][0:3] (8)  packed word from the upstream 2x4 producer stage.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a word.
REQ-008 The block SHALL have port flush  input  1  discard all buffered entries.
REQ-009 The block SHALL have port out_valid  output  1  head entry present.
REQ-010 The block SHALL have port out_ready  input  1  downstream consumes the head entry.
REQ-011 The block SHALL have port out_data  output  [0:1][0:3] (8)  head entry word.
REQ-012 The block SHALL have port out_stamp  output  TS_W  cycle stamp of the head entry.
REQ-013 The block SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal (count != DEPTH); there is no same-cycle bypass when full.
REQ-016 out_valid SHALL equal (count != 0); out_data and out_stamp SHALL be the oldest entry, driven from registers.
REQ-017 A word pushed on edge N SHALL appear on out_data no earlier than after edge N (1-cycle latency when empty).
REQ-018 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-019 Pop when empty and push when full SHALL be impossible by the handshake; the internal pointers SHALL not move.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 flush SHALL take priority over push and pop in the same cycle: count becomes 0, pointers become 0, and the pushed word is discarded.
REQ-022 out_data and out_stamp SHALL hold their last value while out_valid=0; consumers SHALL ignore them.
REQ-023 The stamp counter SHALL be a TS_W-bit free-running counter, incremented by 1 each cycle, wrapping from all-ones to 0.
REQ-024 Each entry SHALL store the stamp counter value present in the cycle the push is accepted.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL set count=0, both pointers=0, stamp counter=0, out_valid=0, in_ready=1, and out_data=0, and out_stamp=0.
REQ-026 Reset asserted mid-operation SHALL discard all entries; a push in the reset cycle SHALL be ignored.
REQ-027 Storage contents SHALL need no reset; only pointers and the count SHALL need it.

Configuration
REQ-028 When macro QJX_STAMP_FIFO_STAMP_EN is defined, the block SHALL include the stamp counter and the per-entry stamp storage, and out_stamp SHALL behave per REQ-023 and REQ-024.
REQ-029 When QJX_STAMP_FIFO_STAMP_EN is undefined, the block SHALL contain no counter or stamp storage, and out_stamp SHALL be constant 0; all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: reset, then push 8'hA5 at cycle 3 with out_ready=0 -> at cycle 4 out_valid=1, out_data=8'hA5, out_stamp=3 (STAMP_EN), count=1.
REQ-031 Scenario: push 8'h01..8'h04 on consecutive cycles with out_ready=0 and DEPTH=4 -> in_ready=0 after the 4th push, a 5th word 8'h05 is not accepted, and the drain yields 01,02,03,04.
REQ-032 Scenario: with count=2, hold in_valid=1 and out_ready=1 for 10 cycles -> count stays 2 and the output order matches the input order across a pointer wrap.
REQ-033 Scenario: with count=3, assert flush together with a push of 8'hFF -> next cycle count=0, out_valid=0, and 8'hFF never appears on out_data.
REQ-034 Scenario: force the stamp counter to all-ones minus 1 and push two words on consecutive cycles -> the stamps are 2^TS_W-2 and 2^TS_W-1, and a third word pushed next cycle carries stamp 0.
REQ-035 Scenario: assert rst_n=0 for one cycle while count=4 and in_valid=1 -> next cycle count=0, in_ready=1, out_valid=0, out_stamp=0; build the same bench without the macro and confirm out_stamp stays 0 throughout.
